stream_minmax: RTL

Streaming reduction stage that consumes a packet of W-bit operands over a valid/ready handshake and reports the minimum, the maximum and their beat indices once the last beat is accepted. The block sits directly downstream of the `cmp` magnitude comparator. It instantiates two copies, one against the running minimum and one against the running maximum, and registers their `o_lt`/`o_gt` decisions into running state. It feeds a single result beat to a downstream consumer over a valid/ready handshake.

---
 rtl/stream_minmax_pkg.sv | 10 +
 rtl/cmp.sv | 39 +++
 rtl/stream_minmax.sv | 123 ++++++++++++
 3 files changed

// File: rtl/stream_minmax_pkg.sv
// Shared types for the stream_minmax reduction stage.
package stream_minmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/cmp.sv
// Magnitude comparator: o_lt/o_eq/o_gt of i_a against i_b, signed or unsigned.
module cmp #(
  parameter int W          = 32,
  parameter int IS_SIGNED  = 1,
  parameter int FPGA_INFER = 0
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_lt,
  output logic         o_eq,
  output logic         o_gt
);

  // Flipping the sign bit maps two's complement onto offset binary, so one
  // unsigned compare serves both modes.
  localparam logic [W-1:0] BIAS = (IS_SIGNED != 0) ? {1'b1, {(W-1){1'b0}}} : '0;

  logic [W-1:0] a_b;
  logic [W-1:0] b_b;

  assign a_b = i_a ^ BIAS;
  assign b_b = i_b ^ BIAS;

  generate
    if (FPGA_INFER != 0) begin : g_sub
      // Single subtractor: the borrow is a<b and a zero difference is a==b.
      logic [W:0] diff;
      assign diff = {1'b0, a_b} - {1'b0, b_b};
      assign o_lt = diff[W];
      assign o_eq = (diff[W-1:0] == '0);
      assign o_gt = ~diff[W] & (diff[W-1:0] != '0);
    end else begin : g_rel
      assign o_lt = (a_b < b_b);
      assign o_eq = (a_b == b_b);
      assign o_gt = (a_b > b_b);
    end
  endgenerate

endmodule

// File: rtl/stream_minmax.sv
// Streaming min/max reduction over a packet; emits min, max, their indices,
// the saturating beat count and an overflow flag once the last beat lands.
module stream_minmax
  import stream_minmax_pkg::*;
#(
  parameter int W          = 32,
  parameter int IS_SIGNED  = 1,
  parameter int FPGA_INFER = 0,
  parameter int IDX_W      = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_vld,
  input  logic [W-1:0]     i_data,
  input  logic             i_last,
  output logic             o_rdy,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [W-1:0]     o_min,
  output logic [IDX_W-1:0] o_min_idx,
  output logic [W-1:0]     o_max,
  output logic [IDX_W-1:0] o_max_idx,
  output logic [IDX_W-1:0] o_cnt,
  output logic             o_ovf
);

  localparam logic [IDX_W-1:0] IDX_SAT = '1;

  // Handshake: a beat moves when i_vld & o_rdy at a rising edge; the result
  // moves when o_vld & i_rdy. Neither ready depends on the matching valid.
  state_t state;

  logic min_lt, min_eq, min_gt;
  logic max_lt, max_eq, max_gt;
  logic take_min, take_max;

  cmp #(.W(W), .IS_SIGNED(IS_SIGNED), .FPGA_INFER(FPGA_INFER)) u_cmp_min (
    .i_a  (i_data),
    .i_b  (o_min),
    .o_lt (min_lt),
    .o_eq (min_eq),
    .o_gt (min_gt)
  );

  cmp #(.W(W), .IS_SIGNED(IS_SIGNED), .FPGA_INFER(FPGA_INFER)) u_cmp_max (
    .i_a  (i_data),
    .i_b  (o_max),
    .o_lt (max_lt),
    .o_eq (max_eq),
    .o_gt (max_gt)
  );

  // Only a strict win replaces; a tie keeps the earlier index.
  assign take_min = min_lt & ~(min_eq | min_gt);
  assign take_max = max_gt & ~(max_eq | max_lt);

  assign o_rdy = (state != EMIT);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      o_vld     <= 1'b0;
      o_min     <= '0;
      o_max     <= '0;
      o_min_idx <= '0;
      o_max_idx <= '0;
      o_cnt     <= '0;
      o_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_vld) begin
            o_min     <= i_data;
            o_max     <= i_data;
            o_min_idx <= '0;
            o_max_idx <= '0;
            o_cnt     <= IDX_W'(1);
            o_ovf     <= 1'b0;
            if (i_last) begin
              state <= EMIT;
              o_vld <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (i_vld) begin
            // The current count is this beat's index, saturated with the count.
            if (take_min) begin
              o_min     <= i_data;
              o_min_idx <= o_cnt;
            end
            if (take_max) begin
              o_max     <= i_data;
              o_max_idx <= o_cnt;
            end
            if (o_cnt == IDX_SAT) begin
              o_ovf <= 1'b1;
            end else begin
              o_cnt <= o_cnt + IDX_W'(1);
            end
            if (i_last) begin
              state <= EMIT;
              o_vld <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (i_rdy) begin
            state <= IDLE;
            o_vld <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          o_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
